// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state type and constants for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} arb_state_t;
  localparam logic [2:0] DBG_FUNC3 = 3'b010;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage (core) and a host debug port (dbg)
//   clk, reset                   : clock, synchronous active-high reset
//   core_rd/wr/addr/wdata/func3  : MEM-stage request; core_stall freezes the pipeline while refused
//   core_rdata                   : read data, valid the cycle after a core read grant
//   dbg_valid/we/addr/wdata      : dbg request, held until dbg_valid & dbg_ready
//   dbg_rvalid/dbg_rdata         : dbg read response pulse, one cycle after the read transfer
//   halt_req/halted              : level request for exclusive dbg access, and its registered status
//   mem_*                        : single-port data memory, 1-cycle read latency
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic                  core_stall,
  output logic [DATA_W-1:0]     core_rdata,
  input  logic                  dbg_valid,
  output logic                  dbg_ready,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  input  logic                  halt_req,
  output logic                  halted,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  arb_state_t state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic rsp_dbg_q, rsp_dbg_d;
  logic core_req, dbg_force, core_gnt, dbg_gnt;
  always_comb begin
    core_req = core_rd | core_wr;
    // dbg has lost STARVE_MAX times in a row against the core: it goes first now
    dbg_force = core_req & dbg_valid & (starve_q == SMAX);
    // no strobes leave the block while reset is held, whatever state_q still says
    core_gnt = ~reset & (state_q == RUN) & core_req & ~dbg_force;
    dbg_gnt = ~reset & dbg_valid & ((state_q == HALTED) | ((state_q == RUN) & (~core_req | dbg_force)));
    core_stall = (state_q != RUN) | (core_req & ~core_gnt);
    dbg_ready = dbg_gnt;
    halted = state_q == HALTED;
    dbg_rvalid = rsp_dbg_q & ~reset;
    dbg_rdata = mem_rdata;
    core_rdata = mem_rdata;
    mem_rd = (core_gnt & core_rd) | (dbg_gnt & ~dbg_we);
    mem_wr = (core_gnt & core_wr) | (dbg_gnt & dbg_we);
    mem_addr = dbg_gnt ? dbg_addr : core_addr;
    mem_wdata = dbg_gnt ? dbg_wdata : core_wdata;
    mem_func3 = dbg_gnt ? DBG_FUNC3 : core_func3;
    starve_d = (dbg_valid & core_gnt) ? ((starve_q == SMAX) ? SMAX : starve_q + 4'd1) : 4'd0;
    rsp_dbg_d = dbg_gnt & ~dbg_we;
    // DRAIN always passes through HALTED, even if halt_req already dropped
    state_d = (state_q == RUN) ? (halt_req ? DRAIN : RUN) :
              (state_q == DRAIN) ? HALTED : (halt_req ? HALTED : RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      starve_q <= 4'd0;
      rsp_dbg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      rsp_dbg_q <= rsp_dbg_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized check of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  localparam int AW = 9, DW = 32, SM = 4;
  logic clk = 0, reset, core_rd, core_wr, core_stall, dbg_valid, dbg_ready, dbg_we, dbg_rvalid;
  logic halt_req, halted, mem_rd, mem_wr;
  logic [AW-1:0] core_addr, dbg_addr, mem_addr;
  logic [DW-1:0] core_wdata, core_rdata, dbg_wdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [2:0] core_func3, mem_func3;
  logic [DW-1:0] mem [0:127];
  logic [DW-1:0] refmem [0:127];
  int tests = 0, fails = 0;
  int mode = 0, starve = 0;
  bit ersp, ecrsp, xfer, cstall, prev_rst;
  logic [DW-1:0] erd, ecd;
  always #5 clk = ~clk;
  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset), .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_func3(core_func3), .core_stall(core_stall), .core_rdata(core_rdata),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .halt_req(halt_req),
    .halted(halted), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata));
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[8:2]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[8:2]];
  end
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // one clock cycle: inputs were driven at the preceding negedge
  task automatic cyc();
    bit cq, dg, cg;
    #1;
    cq = core_rd | core_wr;
    if (reset) begin
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_dbg_ready", dbg_ready, 0);
      check("rst_rvalid", dbg_rvalid, 0);
      if (prev_rst) check("rst_halted", halted, 0);
      mode = 0; starve = 0; ersp = 0; ecrsp = 0; xfer = 0; cstall = 0;
    end else begin
      dg = 0; cg = 0;
      if (mode == 0) begin
        dg = dbg_valid && (!cq || starve == SM);
        cg = cq && !dg;
      end else if (mode == 2) dg = dbg_valid;
      check("core_stall", core_stall, (mode != 0 || (cq && !cg)) ? 1 : 0);
      check("dbg_ready", dbg_ready, dg);
      check("halted", halted, mode == 2 ? 1 : 0);
      check("dbg_rvalid", dbg_rvalid, ersp);
      if (ersp) check("dbg_rdata", dbg_rdata, erd);
      if (ecrsp) check("core_rdata", core_rdata, ecd);
      check("mem_rd", mem_rd, ((cg && core_rd) || (dg && !dbg_we)) ? 1 : 0);
      check("mem_wr", mem_wr, ((cg && core_wr) || (dg && dbg_we)) ? 1 : 0);
      if (cg || dg) begin
        check("mem_addr", mem_addr, dg ? dbg_addr : core_addr);
        check("mem_func3", mem_func3, dg ? 3'b010 : core_func3);
        if (mem_wr) check("mem_wdata", mem_wdata, dg ? dbg_wdata : core_wdata);
      end
      ersp = dg && !dbg_we; erd = refmem[dbg_addr[8:2]];
      ecrsp = cg && core_rd; ecd = refmem[core_addr[8:2]];
      if (dg && dbg_we) refmem[dbg_addr[8:2]] = dbg_wdata;
      if (cg && core_wr) refmem[core_addr[8:2]] = core_wdata;
      starve = (mode == 0 && dbg_valid && cg) ? (starve < SM ? starve + 1 : SM) : 0;
      mode = (mode == 0) ? (halt_req ? 1 : 0) : (mode == 1) ? 2 : (halt_req ? 2 : 0);
      xfer = dg; cstall = cq && !cg;
    end
    prev_rst = reset;
    @(negedge clk);
  endtask
  initial begin
    int n;
    reset = 1; core_rd = 1; core_wr = 0; core_addr = 0; core_wdata = 0; core_func3 = 3'b010;
    dbg_valid = 1; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; halt_req = 0; prev_rst = 0;
    @(negedge clk);
    cyc(); cyc();
    reset = 0; core_rd = 0; dbg_valid = 0;
    cyc();
    core_wr = 1; core_addr = 9'h010; core_wdata = 32'hDEADBEEF;
    cyc();
    core_wr = 0; core_rd = 1;
    cyc();
    core_rd = 0;
    #1 check("core_read_back", core_rdata, 32'hDEADBEEF);
    cyc();
    halt_req = 1;
    cyc(); cyc();
    for (int i = 0; i < 16; i++) begin
      dbg_valid = 1; dbg_we = 1; dbg_addr = 9'(i * 4); dbg_wdata = $urandom;
      cyc();
    end
    for (int i = 0; i < 16; i++) begin
      dbg_we = 0; dbg_addr = 9'(i * 4);
      cyc();
    end
    dbg_valid = 0;
    cyc();
    halt_req = 0;
    cyc();
    core_rd = 1; core_addr = 9'h010;
    cyc();
    core_addr = 9'h000; dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h020;
    n = 0; xfer = 0;
    while (!xfer && n < 10) begin cyc(); n++; end
    check("starve_cycles", n, 5);
    dbg_valid = 0;
    cyc();
    core_rd = 0; halt_req = 1; dbg_valid = 1; dbg_addr = 9'h008;
    cyc();
    dbg_valid = 0;
    cyc(); cyc();
    dbg_valid = 1; dbg_addr = 9'h00C;
    cyc();
    dbg_valid = 0; reset = 1;
    cyc();
    reset = 0; halt_req = 0;
    cyc();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 31) == 0) halt_req = ~halt_req;
      if (!cstall) begin
        n = $urandom_range(0, 3);
        core_rd = (n == 0); core_wr = (n == 1);
        core_addr = 9'($urandom_range(0, 15) * 4); core_wdata = $urandom; core_func3 = 3'($urandom_range(0, 7));
      end
      if (!dbg_valid || xfer) begin
        dbg_valid = $urandom_range(0, 1) == 1; dbg_we = $urandom_range(0, 1) == 1;
        dbg_addr = 9'($urandom_range(0, 15) * 4); dbg_wdata = $urandom;
      end
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
